// File: rtl/upc_loop_monitor_pkg.sv
// Shared definitions for the UPC loop monitor: default counter width,
// busy-flag state type and the saturating increment used by every counter.
package upc_loop_monitor_pkg;

    localparam int          CNT_W_DEF = 32;
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } busy_state_e;

    // Counters up to SAT_MAX_W bits wide; the value sticks at all-ones of `width` bits.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned          width);
        logic [SAT_MAX_W-1:0] limit;
        if (width >= SAT_MAX_W) limit = '1;
        else                    limit = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        return (value >= limit) ? value : value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/upc_loop_monitor_sat_counter.sv
// Saturating event counter: counts enabled cycles, holds at all-ones and
// stops entirely while the monitor is frozen.
module sat_counter
    import upc_loop_monitor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    output logic [CNT_W-1:0] count
);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 count <= '0;
        else if (enable && !freeze) count <= CNT_W'(sat_inc(SAT_MAX_W'(count), CNT_W));
    end

endmodule

// File: rtl/upc_loop_monitor.sv
// Performance monitor for a pipelined module: tracks block-level invocations,
// loop invocations, iteration start/end/quit events and stall cycles.
module upc_loop_monitor
    import upc_loop_monitor_pkg::*;
#(
    parameter int STATE_W = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] quit_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               quit_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               quit_at_end,
    input  logic               finish,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_start_cnt,
    output logic [CNT_W-1:0]   mod_done_cnt,
    output logic [CNT_W-1:0]   mod_busy_cycles,
    output logic               loop_busy,
    output logic               iter_start_pulse,
    output logic               iter_end_pulse,
    output logic               loop_quit_pulse,
    output logic [CNT_W-1:0]   iter_cnt,
    output logic [CNT_W-1:0]   loop_invoc_cnt,
    output logic [CNT_W-1:0]   loop_busy_cycles,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               frozen
);

    busy_state_e mod_state, mod_state_next;
    busy_state_e loop_state, loop_state_next;
    logic        loop_start_q;
    logic        hold;
    logic        ev_iter_start, ev_iter_end, ev_quit;
    logic        mod_start, mod_done, loop_set, loop_clear, stall;
    logic        unused_loop_ready;

    // loop_ready is part of the loop handshake but no statistic depends on it.
    assign unused_loop_ready = loop_ready;

    // The edge that samples finish is already excluded from the statistics.
    assign hold = frozen | finish;

    assign ev_iter_start = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign ev_iter_end   = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign ev_quit       = quit_at_end ? (ev_iter_end & loop_done)
                                       : ((cur_state == quit_state) & quit_enable & ~quit_block);

    assign mod_busy   = (mod_state == ST_BUSY);
    assign loop_busy  = (loop_state == ST_BUSY);
    assign mod_start  = ap_start & (~mod_busy | ap_ready);
    assign mod_done   = ap_done & ap_continue;
    assign loop_set   = loop_start & ~loop_start_q & ~loop_busy;
    assign loop_clear = loop_done & loop_continue;
    assign stall      = loop_busy & (cur_state == iter_start_state) & iter_start_enable & iter_start_block;

    // A start in the same cycle as done keeps the module busy (back-to-back invocation).
    always_comb begin
        // NOTE: defaults first so every path assigns the next state and no latch is inferred.
        mod_state_next  = mod_state;
        loop_state_next = loop_state;
        if (!hold) begin
            if (mod_start)     mod_state_next = ST_BUSY;
            else if (mod_done) mod_state_next = ST_IDLE;
            if (loop_set)        loop_state_next = ST_BUSY;
            else if (loop_clear) loop_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mod_state        <= ST_IDLE;
            loop_state       <= ST_IDLE;
            loop_start_q     <= 1'b0;
            frozen           <= 1'b0;
            iter_start_pulse <= 1'b0;
            iter_end_pulse   <= 1'b0;
            loop_quit_pulse  <= 1'b0;
        end else begin
            mod_state        <= mod_state_next;
            loop_state       <= loop_state_next;
            loop_start_q     <= loop_start;
            frozen           <= frozen | finish;
            iter_start_pulse <= ev_iter_start & ~hold;
            iter_end_pulse   <= ev_iter_end & ~hold;
            loop_quit_pulse  <= ev_quit & ~hold;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mod_start_cnt (
        .clock(clock), .reset(reset), .enable(mod_start), .freeze(hold), .count(mod_start_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_mod_done_cnt (
        .clock(clock), .reset(reset), .enable(mod_done), .freeze(hold), .count(mod_done_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_mod_busy_cycles (
        .clock(clock), .reset(reset), .enable(mod_busy), .freeze(hold), .count(mod_busy_cycles));
    sat_counter #(.CNT_W(CNT_W)) u_iter_cnt (
        .clock(clock), .reset(reset), .enable(ev_iter_end), .freeze(hold), .count(iter_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_loop_invoc_cnt (
        .clock(clock), .reset(reset), .enable(loop_set), .freeze(hold), .count(loop_invoc_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_loop_busy_cycles (
        .clock(clock), .reset(reset), .enable(loop_busy), .freeze(hold), .count(loop_busy_cycles));
    sat_counter #(.CNT_W(CNT_W)) u_stall_cycles (
        .clock(clock), .reset(reset), .enable(stall), .freeze(hold), .count(stall_cycles));

endmodule

// File: tb/tb_upc_loop_monitor.sv
// Scoreboard bench for upc_loop_monitor: directed scenarios plus randomized
// traffic, each cycle checked against a behavioural model of the statistics.
module tb_upc_loop_monitor;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               ap_start, ap_ready, ap_done, ap_continue;
    logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
    logic               iter_start_block, iter_end_block, quit_block;
    logic               iter_start_enable, iter_end_enable, quit_enable;
    logic               loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;
    logic               mod_busy, loop_busy, iter_start_pulse, iter_end_pulse, loop_quit_pulse, frozen;
    logic [CNT_W-1:0]   mod_start_cnt, mod_done_cnt, mod_busy_cycles;
    logic [CNT_W-1:0]   iter_cnt, loop_invoc_cnt, loop_busy_cycles, stall_cycles;
    logic [61:0]        all_out;

    upc_loop_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
        .cur_state(cur_state), .iter_start_state(iter_start_state),
        .iter_end_state(iter_end_state), .quit_state(quit_state),
        .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
        .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
        .quit_enable(quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .quit_at_end(quit_at_end), .finish(finish),
        .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
        .mod_busy_cycles(mod_busy_cycles), .loop_busy(loop_busy),
        .iter_start_pulse(iter_start_pulse), .iter_end_pulse(iter_end_pulse),
        .loop_quit_pulse(loop_quit_pulse), .iter_cnt(iter_cnt), .loop_invoc_cnt(loop_invoc_cnt),
        .loop_busy_cycles(loop_busy_cycles), .stall_cycles(stall_cycles), .frozen(frozen)
    );

    assign all_out = {mod_busy, loop_busy, iter_start_pulse, iter_end_pulse, loop_quit_pulse, frozen,
                      mod_start_cnt, mod_done_cnt, mod_busy_cycles, iter_cnt, loop_invoc_cnt,
                      loop_busy_cycles, stall_cycles};

    always #5 clock = ~clock;

    typedef struct packed {
        logic               ap_start, ap_ready, ap_done, ap_continue;
        logic [STATE_W-1:0] cur, iss, ies, qs;
        logic               isb, ieb, qb, ise, iee, qe;
        logic               loop_start, loop_ready, loop_done, loop_continue, quit_at_end, finish;
    } stim_t;

    typedef struct packed {
        logic             mod_busy, loop_busy, is_p, ie_p, q_p, frozen;
        logic [CNT_W-1:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles;
        logic [CNT_W-1:0] iter_cnt, loop_invoc_cnt, loop_busy_cycles, stall_cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    bit   m_ls_prev;
    int   test_cnt = 0;
    int   fail_cnt = 0;
    int   obs_is, obs_ie, obs_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            if (fail_cnt <= 20)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
        int n;
        n = int'(v) + 1;
        return (n > CNT_MAX) ? v : CNT_W'(n);
    endfunction

    // Reference model: one call per clock edge, evaluated from the rules as stated.
    task automatic model_step(input stim_t s);
        bit is_ev, ie_ev, q_ev, start, done, lset, stall;
        is_ev = (s.cur == s.iss) && s.ise && !s.isb;
        ie_ev = (s.cur == s.ies) && s.iee && !s.ieb;
        q_ev  = s.quit_at_end ? (ie_ev && s.loop_done) : ((s.cur == s.qs) && s.qe && !s.qb);
        if (!m.frozen && !s.finish) begin
            start = s.ap_start && (!m.mod_busy || s.ap_ready);
            done  = s.ap_done && s.ap_continue;
            lset  = s.loop_start && !m_ls_prev && !m.loop_busy;
            stall = m.loop_busy && (s.cur == s.iss) && s.ise && s.isb;
            if (start)       m.mod_start_cnt    = sat(m.mod_start_cnt);
            if (done)        m.mod_done_cnt     = sat(m.mod_done_cnt);
            if (m.mod_busy)  m.mod_busy_cycles  = sat(m.mod_busy_cycles);
            if (m.loop_busy) m.loop_busy_cycles = sat(m.loop_busy_cycles);
            if (stall)       m.stall_cycles     = sat(m.stall_cycles);
            if (lset)        m.loop_invoc_cnt   = sat(m.loop_invoc_cnt);
            if (ie_ev)       m.iter_cnt         = sat(m.iter_cnt);
            if (start)     m.mod_busy = 1'b1;
            else if (done) m.mod_busy = 1'b0;
            if (lset)                              m.loop_busy = 1'b1;
            else if (s.loop_done && s.loop_continue) m.loop_busy = 1'b0;
            m.is_p = is_ev;
            m.ie_p = ie_ev;
            m.q_p  = q_ev;
        end else begin
            m.is_p = 1'b0;
            m.ie_p = 1'b0;
            m.q_p  = 1'b0;
        end
        if (s.finish) m.frozen = 1'b1;
        m_ls_prev = s.loop_start;
    endtask

    task automatic drive_and_model(input stim_t s);
        ap_start = s.ap_start;  ap_ready = s.ap_ready;  ap_done = s.ap_done;  ap_continue = s.ap_continue;
        cur_state = s.cur;  iter_start_state = s.iss;  iter_end_state = s.ies;  quit_state = s.qs;
        iter_start_block = s.isb;  iter_end_block = s.ieb;  quit_block = s.qb;
        iter_start_enable = s.ise;  iter_end_enable = s.iee;  quit_enable = s.qe;
        loop_start = s.loop_start;  loop_ready = s.loop_ready;  loop_done = s.loop_done;
        loop_continue = s.loop_continue;  quit_at_end = s.quit_at_end;  finish = s.finish;
        if (reset) begin
            model_step(s);
            exp_q.push_back(m);
        end
    endtask

    task automatic apply(input stim_t s);
        @(negedge clock);
        drive_and_model(s);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        drive_and_model('0);
        exp_q.delete();
        m = '0;
        m_ls_prev = 1'b0;
        @(negedge clock);
        check("reset_state", 64'(all_out), 64'd0);
        reset = 1'b1;
        drive_and_model('0);
        obs_is = 0;
        obs_ie = 0;
        obs_q  = 0;
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [STATE_W-1:0] onehot();
        return 3'b001 << $urandom_range(0, 2);
    endfunction

    // Monitor: every output cycle pops one expected record and compares all fields.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_mod_busy",         64'(mod_busy),         64'(e.mod_busy));
                check("sb_loop_busy",        64'(loop_busy),        64'(e.loop_busy));
                check("sb_iter_start_pulse", 64'(iter_start_pulse), 64'(e.is_p));
                check("sb_iter_end_pulse",   64'(iter_end_pulse),   64'(e.ie_p));
                check("sb_loop_quit_pulse",  64'(loop_quit_pulse),  64'(e.q_p));
                check("sb_frozen",           64'(frozen),           64'(e.frozen));
                check("sb_mod_start_cnt",    64'(mod_start_cnt),    64'(e.mod_start_cnt));
                check("sb_mod_done_cnt",     64'(mod_done_cnt),     64'(e.mod_done_cnt));
                check("sb_mod_busy_cycles",  64'(mod_busy_cycles),  64'(e.mod_busy_cycles));
                check("sb_iter_cnt",         64'(iter_cnt),         64'(e.iter_cnt));
                check("sb_loop_invoc_cnt",   64'(loop_invoc_cnt),   64'(e.loop_invoc_cnt));
                check("sb_loop_busy_cycles", 64'(loop_busy_cycles), 64'(e.loop_busy_cycles));
                check("sb_stall_cycles",     64'(stall_cycles),     64'(e.stall_cycles));
                obs_is += int'(iter_start_pulse);
                obs_ie += int'(iter_end_pulse);
                obs_q  += int'(loop_quit_pulse);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", test_cnt, fail_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s, base;
        logic [STATE_W-1:0] r_iss, r_ies, r_qs;
        bit r_qae;

        // Module handshake: start at cycle 0, done at cycle 5.
        do_reset();
        s = '0; s.ap_start = 1'b1; apply(s);
        s = '0; repeat (4) apply(s);
        s.ap_done = 1'b1; s.ap_continue = 1'b1; apply(s);
        s = '0; apply(s); apply(s);
        settle();
        check("d1_mod_start_cnt",   64'(mod_start_cnt),   64'd1);
        check("d1_mod_done_cnt",    64'(mod_done_cnt),    64'd1);
        check("d1_mod_busy_cycles", 64'(mod_busy_cycles), 64'd5);
        check("d1_mod_busy",        64'(mod_busy),        64'd0);

        // Back-to-back start with done, then a start without ready while busy.
        s = '0; s.ap_start = 1'b1; apply(s);
        s.ap_ready = 1'b1; s.ap_done = 1'b1; s.ap_continue = 1'b1; apply(s);
        s = '0; s.ap_start = 1'b1; apply(s);
        s = '0; apply(s);
        settle();
        check("d1b_mod_busy",        64'(mod_busy),        64'd1);
        check("d1b_mod_start_cnt",   64'(mod_start_cnt),   64'd3);
        check("d1b_mod_done_cnt",    64'(mod_done_cnt),    64'd2);
        check("d1b_mod_busy_cycles", 64'(mod_busy_cycles), 64'd8);

        // Single-stage loop, 8 iterations, quit at end.
        do_reset();
        base = '0;
        base.iss = 3'b001; base.ies = 3'b001; base.qs = 3'b001;
        base.ise = 1'b1; base.iee = 1'b1; base.qe = 1'b1;
        base.quit_at_end = 1'b1; base.loop_continue = 1'b1;
        s = base; s.loop_start = 1'b1; apply(s);
        for (int i = 0; i < 8; i++) begin
            s = base; s.cur = 3'b001; s.loop_done = (i == 7); apply(s);
        end
        s = base; apply(s); apply(s);
        settle();
        check("d2_iter_cnt",        64'(iter_cnt),       64'd8);
        check("d2_quit_pulses",     64'(obs_q),          64'd1);
        check("d2_loop_invoc_cnt",  64'(loop_invoc_cnt), 64'd1);
        check("d2_loop_busy",       64'(loop_busy),      64'd0);

        // Three one-hot stages cycling four times.
        do_reset();
        base = '0;
        base.iss = 3'b001; base.ies = 3'b100; base.qs = 3'b010;
        base.ise = 1'b1; base.iee = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int st = 0; st < 3; st++) begin
                s = base; s.cur = 3'b001 << st; s.loop_start = (k == 0 && st == 0); apply(s);
            end
        end
        s = base; apply(s);
        settle();
        check("d3_start_pulses", 64'(obs_is),   64'd4);
        check("d3_end_pulses",   64'(obs_ie),   64'd4);
        check("d3_iter_cnt",     64'(iter_cnt), 64'd4);
        check("d3_quit_pulses",  64'(obs_q),    64'd0);

        // Stall: blocked start stage, first while idle (not counted), then 3 cycles while busy.
        do_reset();
        base = '0;
        base.iss = 3'b001; base.ies = 3'b100; base.ise = 1'b1; base.iee = 1'b1;
        s = base; s.cur = 3'b001; s.isb = 1'b1; apply(s);
        s = base; s.loop_start = 1'b1; apply(s);
        s = base; s.cur = 3'b001; s.isb = 1'b1; repeat (3) apply(s);
        s = base; s.cur = 3'b001; apply(s);
        s = base; apply(s);
        settle();
        check("d4_stall_cycles",  64'(stall_cycles), 64'd3);
        check("d4_start_pulses",  64'(obs_is),       64'd1);

        // Finish mid-loop, then further events must not change anything.
        do_reset();
        base = '0;
        base.iss = 3'b001; base.ies = 3'b001; base.ise = 1'b1; base.iee = 1'b1;
        base.quit_at_end = 1'b1; base.loop_continue = 1'b1;
        s = base; s.loop_start = 1'b1; apply(s);
        s = base; s.cur = 3'b001; repeat (3) apply(s);
        s.finish = 1'b1; apply(s);
        s = base; s.cur = 3'b001; s.ap_start = 1'b1; apply(s);
        s = base; s.cur = 3'b001; apply(s); apply(s);
        s.loop_done = 1'b1; apply(s);
        settle();
        check("d5_frozen",           64'(frozen),           64'd1);
        check("d5_iter_cnt",         64'(iter_cnt),         64'd3);
        check("d5_loop_busy",        64'(loop_busy),        64'd1);
        check("d5_loop_busy_cycles", 64'(loop_busy_cycles), 64'd3);
        check("d5_mod_start_cnt",    64'(mod_start_cnt),    64'd0);
        check("d5_quit_pulses",      64'(obs_q),            64'd0);

        // Asynchronous reset in the middle of a loop and a module invocation.
        do_reset();
        base = '0;
        base.iss = 3'b001; base.ies = 3'b001; base.ise = 1'b1; base.iee = 1'b1;
        s = base; s.loop_start = 1'b1; s.ap_start = 1'b1; apply(s);
        s = base; s.cur = 3'b001; repeat (3) apply(s);
        @(posedge clock);
        #2;
        check("d6_pre_reset_iter", 64'(iter_cnt), 64'd3);
        #1;
        reset = 1'b0;
        #1;
        check("d6_async_reset_all", 64'(all_out), 64'd0);
        do_reset();

        // Saturation of busy and iteration counters.
        base = '0;
        base.ies = 3'b001; base.iee = 1'b1; base.cur = 3'b001;
        s = base; s.ap_start = 1'b1; s.loop_start = 1'b1; apply(s);
        s = base; repeat (300) apply(s);
        settle();
        check("d7_iter_sat",        64'(iter_cnt),         64'(CNT_MAX));
        check("d7_mod_busy_sat",    64'(mod_busy_cycles),  64'(CNT_MAX));
        check("d7_loop_busy_sat",   64'(loop_busy_cycles), 64'(CNT_MAX));
        check("d7_loop_invoc_cnt",  64'(loop_invoc_cnt),   64'd1);

        // Randomized traffic; the last block freezes part-way through.
        for (int b = 0; b < 4; b++) begin
            do_reset();
            r_iss = onehot(); r_ies = onehot(); r_qs = onehot();
            r_qae = 1'($urandom_range(0, 1));
            for (int c = 0; c < 500; c++) begin
                s = '0;
                s.iss = r_iss; s.ies = r_ies; s.qs = r_qs; s.quit_at_end = r_qae;
                s.ap_start      = ($urandom_range(0, 9) < 3);
                s.ap_ready      = ($urandom_range(0, 9) < 3);
                s.ap_done       = ($urandom_range(0, 9) < 2);
                s.ap_continue   = ($urandom_range(0, 9) < 7);
                s.cur           = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : onehot();
                s.isb           = ($urandom_range(0, 9) < 2);
                s.ieb           = ($urandom_range(0, 9) < 2);
                s.qb            = ($urandom_range(0, 9) < 2);
                s.ise           = ($urandom_range(0, 9) < 8);
                s.iee           = ($urandom_range(0, 9) < 8);
                s.qe            = ($urandom_range(0, 9) < 8);
                s.loop_start    = ($urandom_range(0, 9) < 3);
                s.loop_ready    = ($urandom_range(0, 9) < 5);
                s.loop_done     = ($urandom_range(0, 9) < 2);
                s.loop_continue = ($urandom_range(0, 9) < 7);
                s.finish        = (b == 3 && c == 400);
                apply(s);
            end
            settle();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/upc_loop_monitor.md
UPC_LOOP_MONITOR -- requirements
Module: upc_loop_monitor

Interface
REQ-001 SHALL have parameter STATE_W, default 1, width of loop FSM state vectors (one-hot).
REQ-002 SHALL have parameter CNT_W, default 32, width of every counter output.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ap_start, ap_ready, ap_done, ap_continue  input  1 each  monitored module block-level handshake.
REQ-006 cur_state, iter_start_state, iter_end_state, quit_state  input  STATE_W each  loop FSM current state and reference states.
REQ-007 iter_start_block, iter_end_block, quit_block  input  1 each  stage stall (subdone) flags.
REQ-008 iter_start_enable, iter_end_enable, quit_enable  input  1 each  pipeline iteration-enable registers.
REQ-009 loop_start, loop_ready, loop_done, loop_continue, quit_at_end  input  1 each  loop handshake and quit mode.
REQ-010 finish  input  1  end of simulation/run; freezes all statistics.
REQ-011 mod_busy  output  1  module invocation in progress.
REQ-012 mod_start_cnt, mod_done_cnt, mod_busy_cycles  output  CNT_W each  module statistics.
REQ-013 loop_busy, iter_start_pulse, iter_end_pulse, loop_quit_pulse  output  1 each  loop status and event pulses.
REQ-014 iter_cnt, loop_invoc_cnt, loop_busy_cycles, stall_cycles  output  CNT_W each  loop statistics.
REQ-015 frozen  output  1  statistics frozen after finish.

Function
REQ-016 State match SHALL be bitwise equality cur_state == reference state.
REQ-017 Events: iter_start = match(iter_start_state) & iter_start_enable & ~iter_start_block; iter_end = match(iter_end_state) & iter_end_enable & ~iter_end_block; quit = quit_at_end ? (iter_end & loop_done) : (match(quit_state) & quit_enable & ~quit_block).
REQ-018 All outputs SHALL be registered; every event is reflected one clock after the sampling edge.
REQ-019 Module start = ap_start & ~mod_busy; mod_busy sets on start, clears on ap_done & ap_continue; simultaneous start and done with mod_busy=1 leaves mod_busy=1 (back-to-back).
REQ-020 mod_start_cnt increments on each start (ap_start & ap_ready when busy counts new start); mod_done_cnt increments on ap_done & ap_continue; mod_busy_cycles increments each cycle mod_busy=1.
REQ-021 loop_busy sets on loop_start rising while idle, clears on loop_done & loop_continue; loop_invoc_cnt increments on each set.
REQ-022 iter_start_pulse/iter_end_pulse/loop_quit_pulse SHALL be one-cycle registered copies of the REQ-017 events; iter_cnt increments per iter_end.
REQ-023 stall_cycles increments each cycle loop_busy=1 and match(iter_start_state) & iter_start_enable & iter_start_block.
REQ-024 loop_busy_cycles increments each cycle loop_busy=1.
REQ-025 Counters SHALL saturate at all-ones, never wrap.
REQ-026 On finish=1 sampled, frozen SHALL set and remain 1; while frozen no counter or busy flag changes and pulses are 0.
REQ-027 Events with loop_busy=0 SHALL still count iterations (no gating) except stall_cycles and loop_busy_cycles.

Reset
REQ-028 reset=0 SHALL asynchronously clear every output and internal register to 0, including frozen; reset mid-invocation discards it.

Structure
REQ-029 A shared package SHALL hold CNT_W default and a saturating-increment function.
REQ-030 One sub-module, sat_counter (enable, freeze, CNT_W), SHALL be instantiated per counter.

Verification
REQ-031 ap_start=1 at cycle 0, ap_done=1 at cycle 5 -> mod_busy 1 for cycles 1..5, mod_start_cnt=1, mod_done_cnt=1, mod_busy_cycles=5.
REQ-032 STATE_W=1, enables=1, blocks=0, 8 cycles in stage0, loop_done on 8th, quit_at_end=1 -> iter_cnt=8, one loop_quit_pulse, loop_invoc_cnt=1.
REQ-033 STATE_W=3, one-hot stages 001/010/100 cycling 4 times -> iter_start_pulse 4, iter_end_pulse 4, only in states 001 and 100.
REQ-034 iter_start_block=1 for 3 cycles in start state while busy -> stall_cycles=3, no iter_start_pulse during stall.
REQ-035 finish=1 mid-loop then further events -> frozen=1, counters hold values at finish.
REQ-036 reset=0 mid-loop asynchronously -> all outputs 0 before next clock edge.
